// File: rtl/sram_xfer_sched.sv
// Round-robin scheduler sharing one SRAM DMA engine between two requesters.
// Validates lengths, drives level-held strobes, tracks the done handshake with a timeout.
module sram_xfer_sched #(
  parameter int unsigned MAX_LEN    = 512,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       rw0_i,
  input  logic       rw1_i,
  input  logic [9:0] len0_i,
  input  logic [9:0] len1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic       err0_o,
  output logic       err1_o,
  output logic       xfer_read_o,
  output logic       xfer_write_o,
  output logic [9:0] xfer_len_o,
  input  logic       xfer_done_i,
  output logic       busy_o
);

  localparam int unsigned LEN_W = 10;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic               owner_q, owner_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_q, busy_d;

  logic               any_req_c;
  logic               cand_c;
  logic               cand_rw_c;
  logic [LEN_W-1:0]   cand_len_c;
  logic               len_ok_c;
  logic               complete_c;
  logic               timeout_c;
  logic [1:0]         owner_mask_c;

  // Candidate: requester at rr pointer if asking, otherwise the other one
  assign any_req_c    = req0_i | req1_i;
  assign cand_c       = rr_q ? req1_i : ~req0_i;
  assign cand_len_c   = cand_c ? len1_i : len0_i;
  assign cand_rw_c    = cand_c ? rw1_i : rw0_i;
  assign len_ok_c     = (cand_len_c != '0) && !cand_len_c[0] && (cand_len_c <= MAX_LEN_V);

  assign complete_c   = (state_q == S_RUN) && xfer_done_i;
  assign timeout_c    = (timer_q == TMR_LAST);
  assign owner_mask_c = owner_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    len_d   = len_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    busy_d  = 1'b0;

    case (state_q)
      // Skip one cycle after a reject so the requester can drop req on its done pulse
      S_IDLE: begin
        if (any_req_c && (done_q == 2'b00)) begin
          rr_d = ~cand_c;
          if (len_ok_c) begin
            owner_d = cand_c;
            gnt_d   = cand_c ? 2'b10 : 2'b01;
            len_d   = cand_len_c;
            wr_d    = cand_rw_c;
            rd_d    = ~cand_rw_c;
            timer_d = '0;
            state_d = S_ACK;
          end else begin
            done_d  = cand_c ? 2'b10 : 2'b01;
            err_d   = cand_c ? 2'b10 : 2'b01;
          end
        end
      end

      S_ACK, S_RUN: begin
        timer_d = timer_q + TMR_W'(1);
        if ((state_q == S_ACK) && !xfer_done_i) begin
          state_d = S_RUN;
        end
        // A completion seen on the last timer cycle still counts as success
        if (complete_c || timeout_c) begin
          gnt_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = owner_mask_c;
          err_d   = complete_c ? 2'b00 : owner_mask_c;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign gnt0_o       = gnt_q[0];
  assign gnt1_o       = gnt_q[1];
  assign done0_o      = done_q[0];
  assign done1_o      = done_q[1];
  assign err0_o       = err_q[0];
  assign err1_o       = err_q[1];
  assign xfer_read_o  = rd_q;
  assign xfer_write_o = wr_q;
  assign xfer_len_o   = len_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_sram_xfer_sched.sv
// Bench for sram_xfer_sched: procedural transaction model checked every cycle,
// an engine model with programmable done timing, and directed scenarios.
module tb_sram_xfer_sched;

  localparam int MAXL = 512;
  localparam int GAPC = 4;
  localparam int TMO  = 100;

  logic       clk;
  logic       reset;
  logic       req0, req1, rw0, rw1;
  logic [9:0] len0, len1;
  logic       xfer_done;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic       xfer_read, xfer_write, busy;
  logic [9:0] xfer_len;

  sram_xfer_sched #(
    .MAX_LEN    (MAXL),
    .GAP_CYCLES (GAPC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req0_i       (req0),
    .req1_i       (req1),
    .rw0_i        (rw0),
    .rw1_i        (rw1),
    .len0_i       (len0),
    .len1_i       (len1),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1),
    .done0_o      (done0),
    .done1_o      (done1),
    .err0_o       (err0),
    .err1_o       (err1),
    .xfer_read_o  (xfer_read),
    .xfer_write_o (xfer_write),
    .xfer_len_o   (xfer_len),
    .xfer_done_i  (xfer_done),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] e_gnt, e_done, e_err;
  logic       e_rd, e_wr, e_busy;
  logic [9:0] e_len;

  function automatic bit len_ok(input logic [9:0] l);
    return (l != 10'd0) && !l[0] && (int'(l) <= MAXL);
  endfunction

  task automatic clear_exp();
    e_gnt = '0; e_done = '0; e_err = '0;
    e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_len = '0;
  endtask

  // Model: walk one request at a time; reset restarts it from the top
  initial begin : model
    bit rr, x, skip, seen_low, ok, aborted;
    int n;
    rr = 1'b0; skip = 1'b0;
    clear_exp();
    forever begin
      if (reset) begin
        clear_exp(); rr = 1'b0; skip = 1'b0;
        wait (!reset);
      end
      @(posedge clk or posedge reset);
      if (reset) continue;
      e_done = '0; e_err = '0;
      if (skip) begin skip = 1'b0; continue; end
      if (!req0 && !req1) continue;
      x  = rr ? req1 : !req0;
      rr = !x;
      if (!len_ok(x ? len1 : len0)) begin
        e_done[x] = 1'b1; e_err[x] = 1'b1; skip = 1'b1;
        continue;
      end
      e_gnt[x] = 1'b1;
      e_len    = x ? len1 : len0;
      e_wr     = x ? rw1 : rw0;
      e_rd     = !e_wr;
      e_busy   = 1'b1;
      n = 0; seen_low = 1'b0; ok = 1'b0; aborted = 1'b0;
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin aborted = 1'b1; break; end
        n++;
        if (seen_low && xfer_done) begin ok = 1'b1; break; end
        if (n == TMO) break;
        if (!xfer_done) seen_low = 1'b1;
      end
      if (aborted) continue;
      e_gnt = '0; e_rd = 1'b0; e_wr = 1'b0;
      e_done[x] = 1'b1; e_err[x] = !ok;
      for (int g = 0; g < GAPC; g++) begin
        @(posedge clk or posedge reset);
        if (reset) break;
        e_done = '0; e_err = '0;
        if (g == GAPC - 1) e_busy = 1'b0;
      end
    end
  end

  // ---------------- engine model ----------------
  int ack_dly, run_dly, ecnt;
  bit hang;
  initial begin
    xfer_done = 1'b0; ecnt = 0;
    ack_dly = 3; run_dly = 43; hang = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        xfer_done = 1'b0; ecnt = 0;
      end else if (xfer_read || xfer_write) begin
        ecnt++;
        if (ecnt == ack_dly) xfer_done = 1'b0;
        if (ecnt == run_dly && !hang) xfer_done = 1'b1;
      end else begin
        ecnt = 0;
      end
    end
  end

  // ---------------- requesters: drop req once enough dones are seen ----------------
  int want0 = 0, want1 = 0;
  initial begin
    forever begin
      @(negedge clk); #2;
      if (done0 && want0 > 0) begin want0--; if (want0 == 0) req0 = 1'b0; end
      if (done1 && want1 > 0) begin want1--; if (want1 == 0) req1 = 1'b0; end
    end
  end

  // ---------------- compare + statistics ----------------
  int n_rd, n_wr, n_done0, n_done1, n_err0, n_err1, n_gnt0, n_gnt1;
  int min_gap, low_run;
  bit had_strobe;
  int glog[$];
  logic pg0 = 1'b0, pg1 = 1'b0;

  task automatic clr_stats();
    n_rd = 0; n_wr = 0; n_done0 = 0; n_done1 = 0; n_err0 = 0; n_err1 = 0;
    n_gnt0 = 0; n_gnt1 = 0; min_gap = 1000; low_run = 0; had_strobe = 1'b0;
    glog.delete();
  endtask

  initial begin
    clr_stats();
    forever begin
      @(negedge clk); #1;
      chk("gnt0",   32'(gnt0),       32'(e_gnt[0]));
      chk("gnt1",   32'(gnt1),       32'(e_gnt[1]));
      chk("done0",  32'(done0),      32'(e_done[0]));
      chk("done1",  32'(done1),      32'(e_done[1]));
      chk("err0",   32'(err0),       32'(e_err[0]));
      chk("err1",   32'(err1),       32'(e_err[1]));
      chk("xread",  32'(xfer_read),  32'(e_rd));
      chk("xwrite", 32'(xfer_write), 32'(e_wr));
      chk("busy",   32'(busy),       32'(e_busy));
      if (e_rd || e_wr) chk("xlen", 32'(xfer_len), 32'(e_len));
      if (xfer_read)  n_rd++;
      if (xfer_write) n_wr++;
      if (done0) n_done0++;
      if (done1) n_done1++;
      if (err0)  n_err0++;
      if (err1)  n_err1++;
      if (gnt0)  n_gnt0++;
      if (gnt1)  n_gnt1++;
      if (gnt0 && !pg0) glog.push_back(0);
      if (gnt1 && !pg1) glog.push_back(1);
      pg0 = gnt0; pg1 = gnt1;
      if (xfer_read || xfer_write) begin
        if (had_strobe && low_run > 0 && low_run < min_gap) min_gap = low_run;
        had_strobe = 1'b1; low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic wait_served(input string name, input int limit);
    int c = 0;
    while ((want0 != 0 || want1 != 0) && c < limit) begin
      @(negedge clk); c++;
    end
    chk({name, "_served"}, 32'(want0 + want1), 32'd0);
    want0 = 0; want1 = 0; req0 = 1'b0; req1 = 1'b0;
    repeat (GAPC + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int c;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0; len0 = '0; len1 = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_len",  32'(xfer_len), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: read of 512 bytes; inputs changed mid-transfer must be ignored
    clr_stats(); ack_dly = 3; run_dly = 43; hang = 1'b0;
    rw0 = 1'b0; len0 = 10'd512; want0 = 1; req0 = 1'b1;
    repeat (5) @(negedge clk);
    len0 = 10'd7; rw0 = 1'b1;
    wait_served("t1", 500);
    chk("t1_rd_cycles",  32'(n_rd), 32'd43);
    chk("t1_wr_cycles",  32'(n_wr), 32'd0);
    chk("t1_gnt_cycles", 32'(n_gnt0), 32'd43);
    chk("t1_done",       32'(n_done0), 32'd1);
    chk("t1_err",        32'(n_err0), 32'd0);

    // 6: write with xfer_done still high; req dropped mid-transfer
    clr_stats(); ack_dly = 5; run_dly = 12;
    chk("t6_done_high", 32'(xfer_done), 32'd1);
    rw0 = 1'b1; len0 = 10'd2; want0 = 1; req0 = 1'b1;
    repeat (3) @(negedge clk);
    req0 = 1'b0;
    wait_served("t6", 500);
    chk("t6_wr_cycles", 32'(n_wr), 32'd12);
    chk("t6_done",      32'(n_done0), 32'd1);
    chk("t6_err",       32'(n_err0), 32'd0);

    // 3: illegal lengths on requester 1
    clr_stats();
    len1 = 10'd0;   rw1 = 1'b0; want1 = 1; req1 = 1'b1; wait_served("t3a", 50);
    len1 = 10'd7;               want1 = 1; req1 = 1'b1; wait_served("t3b", 50);
    len1 = 10'd514;             want1 = 1; req1 = 1'b1; wait_served("t3c", 50);
    chk("t3_done",    32'(n_done1), 32'd3);
    chk("t3_err",     32'(n_err1), 32'd3);
    chk("t3_gnt",     32'(n_gnt1), 32'd0);
    chk("t3_strobes", 32'(n_rd + n_wr), 32'd0);

    // 2: both requesters held for two transfers each
    clr_stats(); ack_dly = 3; run_dly = 20;
    rw0 = 1'b0; len0 = 10'd64; rw1 = 1'b1; len1 = 10'd128;
    want0 = 2; want1 = 2; req0 = 1'b1; req1 = 1'b1;
    wait_served("t2", 1000);
    chk("t2_ngrants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    chk("t2_gap_ok", 32'(min_gap >= GAPC), 32'd1);
    chk("t2_done0",  32'(n_done0), 32'd2);
    chk("t2_done1",  32'(n_done1), 32'd2);
    chk("t2_rd",     32'(n_rd), 32'd40);
    chk("t2_wr",     32'(n_wr), 32'd40);

    // 4: engine never completes, then a normal request
    clr_stats(); ack_dly = 3; hang = 1'b1;
    rw0 = 1'b1; len0 = 10'd100; want0 = 1; req0 = 1'b1;
    wait_served("t4a", 500);
    chk("t4_wr_cycles", 32'(n_wr), 32'(TMO));
    chk("t4_done0",     32'(n_done0), 32'd1);
    chk("t4_err0",      32'(n_err0), 32'd1);
    hang = 1'b0; run_dly = 30;
    rw1 = 1'b0; len1 = 10'd10; want1 = 1; req1 = 1'b1;
    wait_served("t4b", 500);
    chk("t4_rd_cycles", 32'(n_rd), 32'd30);
    chk("t4_done1",     32'(n_done1), 32'd1);
    chk("t4_err1",      32'(n_err1), 32'd0);

    // 5: reset during RUN, then round-robin pointer must be back at 0
    clr_stats(); ack_dly = 3; run_dly = 43;
    rw0 = 1'b0; len0 = 10'd16; want0 = 1; req0 = 1'b1;
    c = 0;
    while (!xfer_read && c < 200) begin @(negedge clk); c++; end
    chk("t5_started", 32'(xfer_read), 32'd1);
    repeat (10) @(negedge clk);
    #3 reset = 1'b1; want0 = 0; req0 = 1'b0;
    #1;
    chk("t5_rst_rd",   32'(xfer_read), 32'd0);
    chk("t5_rst_wr",   32'(xfer_write), 32'd0);
    chk("t5_rst_gnt0", 32'(gnt0), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_stats(); run_dly = 10;
    len1 = 10'd4; rw1 = 1'b1;
    want0 = 1; want1 = 1; req0 = 1'b1; req1 = 1'b1;
    wait_served("t5", 500);
    chk("t5_ngrants", 32'(glog.size() >= 1), 32'd1);
    if (glog.size() >= 1) chk("t5_first_grant", 32'(glog[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
